riscv_mc_controller: RTL

//  Multi-cycle sequencer for the single-issue RV32I core. Owns the PC and the

---
 rtl/riscv_defs.sv | 31 +++
 rtl/riscv_mc_controller_pkg.sv | 22 ++
 rtl/riscv_mc_controller_ack_timer.sv | 46 ++++
 rtl/riscv_mc_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// riscv_defs: core-wide control-field encodings that the decoder produces
// and the multi-cycle controller consumes.
//   rf_wen_e   register-file write enable
//   mem_wen_e  data-memory write enable
//   wb_sel_e   writeback source select
//   pc_sel_e   next-PC source select
package riscv_defs;

  typedef enum logic {
    RF_NONE  = 1'b0,
    RF_WRITE = 1'b1
  } rf_wen_e;

  typedef enum logic {
    MEM_NONE  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_wen_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4    = 2'd0,
    PC_ALU      = 2'd1,
    PC_B_TARGET = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/riscv_mc_controller_pkg.sv
// riscv_mc_controller_pkg: shared types for the multi-cycle sequencer.
//   mc_state_e    sequencer states
//   trap_cause_e  encoding reported on trap_cause_o
package riscv_mc_controller_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } mc_state_e;

  typedef enum logic [1:0] {
    TRAP_ILLEGAL  = 2'd0,
    TRAP_IMEM_TO  = 2'd1,
    TRAP_DMEM_TO  = 2'd2,
    TRAP_MISALIGN = 2'd3
  } trap_cause_e;

endpackage

// File: rtl/riscv_mc_controller_ack_timer.sv
// riscv_ack_timer: counts the cycles a memory request has waited for its ack.
// Parameters:
//   TIMEOUT    cycles a request may wait; 0 disables expiry
// Ports:
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   clear_i    hold the counter at zero (no request outstanding)
//   count_i    request asserted and not acknowledged this cycle
//   expired_o  this is the TIMEOUT-th unacknowledged cycle
module riscv_ack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the number of unacknowledged cycles already seen, so
  // the request expires during the cycle in which it reaches TIMEOUT.
  assign expired_o = (TIMEOUT != 0) && count_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multi-cycle sequencer for the single-issue RV32I core.
// Owns PC and IR, drives the imem/dmem request handshakes and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB. Traps (sticky until reset)
// on illegal instruction, memory ack timeout or misaligned next PC.
// Parameters: RESET_PC (PC after reset), TIMEOUT (ack wait limit, 0 = none).
// Ports:
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake
//   ir_o                                     instruction register to decoder
//   dec_valid, dec_rf_wen, dec_mem_wen,
//   dec_wb_sel, dec_pc_sel                   decoder control fields
//   alu_out, br_taken, br_target             datapath results
//   dmem_req/dmem_we/dmem_ack                data access handshake
//   rf_we, retire_o                          1-cycle writeback/retire pulses
//   pc_o, trap_o, trap_cause_o               architectural status
// Optional feature (macro RISCV_MC_PERF_EN): adds 64-bit cycle_cnt_o and
// instret_o performance counters.
module riscv_mc_controller
  import riscv_defs::*;
  import riscv_mc_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_o,
  input  logic        dec_valid,
  input  rf_wen_e     dec_rf_wen,
  input  mem_wen_e    dec_mem_wen,
  input  wb_sel_e     dec_wb_sel,
  input  pc_sel_e     dec_pc_sel,
  input  logic [31:0] alu_out,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        retire_o,
  output logic [31:0] pc_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
`endif
);

  mc_state_e   state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_q, alu_d;
  rf_wen_e     rf_wen_q, rf_wen_d;
  mem_wen_e    mem_wen_q, mem_wen_d;
  wb_sel_e     wb_sel_q, wb_sel_d;
  pc_sel_e     pc_sel_q, pc_sel_d;
  // Low from reset until the first clock edge afterwards, so no request is
  // visible while reset is asserted or in the cycle it is released.
  logic        run_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misalign;
  logic        tmr_clear;
  logic        tmr_count;
  logic        tmr_expired;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    case (pc_sel_q)
      PC_ALU:      next_pc = alu_q;
      PC_B_TARGET: next_pc = br_taken ? br_target : pc_plus4;
      default:     next_pc = pc_plus4;
    endcase
  end

  assign misalign = (next_pc[1:0] != 2'b00);

  assign imem_req     = run_q && (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign dmem_req     = (state_q == MEM);
  assign dmem_we      = (state_q == MEM) && (mem_wen_q == MEM_WRITE);
  assign rf_we        = (state_q == WB) && (rf_wen_q == RF_WRITE);
  assign retire_o     = (state_q == WB) && !misalign;
  assign ir_o         = ir_q;
  assign pc_o         = pc_q;
  assign trap_o       = (state_q == TRAP);
  assign trap_cause_o = cause_q;

  // The timer only runs while a request is outstanding; every other state
  // holds it cleared, which gives a fresh count on entry to FETCH or MEM.
  assign tmr_clear = (state_q != FETCH) && (state_q != MEM);
  assign tmr_count = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

  riscv_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .count_i   (tmr_count),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    rf_wen_d  = rf_wen_q;
    mem_wen_d = mem_wen_q;
    wb_sel_d  = wb_sel_q;
    pc_sel_d  = pc_sel_q;
    case (state_q)
      FETCH: begin
        // Ack is checked before expiry so a last-cycle ack still completes.
        if (imem_req) begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = DECODE;
          end else if (tmr_expired) begin
            cause_d = TRAP_IMEM_TO;
            state_d = TRAP;
          end
        end
      end
      DECODE: begin
        if (!dec_valid) begin
          cause_d = TRAP_ILLEGAL;
          state_d = TRAP;
        end else begin
          rf_wen_d  = dec_rf_wen;
          mem_wen_d = dec_mem_wen;
          wb_sel_d  = dec_wb_sel;
          pc_sel_d  = dec_pc_sel;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        alu_d = alu_out;
        if ((wb_sel_q == WB_MEM) || (mem_wen_q == MEM_WRITE)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          state_d = WB;
        end else if (tmr_expired) begin
          cause_d = TRAP_DMEM_TO;
          state_d = TRAP;
        end
      end
      WB: begin
        // A misaligned target keeps the faulting PC visible in pc_o.
        if (misalign) begin
          cause_d = TRAP_MISALIGN;
          state_d = TRAP;
        end else begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cause_q   <= TRAP_ILLEGAL;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_q     <= '0;
      rf_wen_q  <= RF_NONE;
      mem_wen_q <= MEM_NONE;
      wb_sel_q  <= WB_ALU;
      pc_sel_q  <= PC_PLUS4;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      rf_wen_q  <= rf_wen_d;
      mem_wen_q <= mem_wen_d;
      wb_sel_q  <= wb_sel_d;
      pc_sel_q  <= pc_sel_d;
      run_q     <= 1'b1;
    end
  end

`ifdef RISCV_MC_PERF_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    if (state_q != TRAP) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
    end
    if (retire_o) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule
